li_expander: RTL and testbench



---
 rtl/rv_enc_pkg.sv | 20 ++
 rtl/imm_encoder.sv | 24 ++
 rtl/li_expander.sv | 122 ++++++++++++
 tb/tb_li_expander.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoding constants and the expander state type.
// Format select codes match the decode-side immediate extraction.
package rv_enc_pkg;

    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_OPIMM  = 7'b0010011;
    localparam logic [2:0]  F3_ADDI   = 3'b000;
    localparam logic [31:0] NOP       = 32'h00000013;

    localparam logic [2:0]  FMT_ITYPE = 3'b000;
    localparam logic [2:0]  FMT_UTYPE = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ONE    = 2'd1,
        FIRST  = 2'd2,
        SECOND = 2'd3
    } state_t;

endpackage

// File: rtl/imm_encoder.sv
// Packs an immediate plus register fields into an I-type or U-type word.
// I-type takes imm[11:0]; U-type takes imm[31:12], mirroring how decode rebuilds them.
module imm_encoder
    import rv_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    input  logic [4:0]  rs1,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [6:0]  opcode,
    output logic [31:0] instr
);

    always_comb begin
        instr = '0;
        case (fmt)
            FMT_ITYPE: instr = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_UTYPE: instr = {imm[31:12], rd, opcode};
            default:   instr = '0;
        endcase
    end

endmodule

// File: rtl/li_expander.sv
// Expands a load-immediate request into one or two RV32I words (LUI and/or ADDI).
// The output word is registered; only rd and the low 12 bits survive into SECOND.
module li_expander
    import rv_enc_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_last,
    output logic [CNT_W-1:0] emit_count
);

    state_t           state;
    state_t           next_state;
    logic [4:0]       rd_q;
    logic [11:0]      lo_q;
    logic [31:0]      instr_q;
    logic [CNT_W-1:0] count_q;

    logic             accept;
    logic             handoff;
    logic             fits_12;
    logic             low_zero;
    logic [31:0]      rounded;

    logic [2:0]       enc_fmt;
    logic [31:0]      enc_imm;
    logic [4:0]       enc_rs1;
    logic [4:0]       enc_rd;
    logic [6:0]       enc_op;
    logic [31:0]      enc_word;
    logic [31:0]      next_word;

    assign out_valid  = (state != IDLE);
    assign out_last   = (state == ONE) || (state == SECOND);
    assign in_ready   = (state == IDLE) || (out_last && out_ready);
    assign out_instr  = instr_q;
    assign emit_count = count_q;

    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;
    assign fits_12  = (in_value[31:11] == '0) || (in_value[31:11] == '1);
    assign low_zero = (in_value[11:0] == 12'h000);
    // Rounding up by 0x800 pre-compensates for the sign-extended ADDI that follows.
    assign rounded  = in_value + 32'h0000_0800;

    // FIRST and accept never coincide, so one encoder serves both the plan and the ADDI follow-up.
    always_comb begin
        enc_fmt    = FMT_ITYPE;
        enc_imm    = in_value;
        enc_rs1    = 5'd0;
        enc_rd     = in_rd;
        enc_op     = OP_OPIMM;
        next_state = ONE;
        if (state == FIRST) begin
            enc_imm    = {20'h00000, lo_q};
            enc_rs1    = rd_q;
            enc_rd     = rd_q;
            next_state = SECOND;
        end else if (in_rd == 5'd0) begin
            next_state = ONE;
        end else if (fits_12) begin
            next_state = ONE;
        end else if (low_zero) begin
            enc_fmt = FMT_UTYPE;
            enc_op  = OP_LUI;
        end else begin
            enc_fmt    = FMT_UTYPE;
            enc_imm    = rounded;
            enc_op     = OP_LUI;
            next_state = FIRST;
        end
        next_word = enc_word;
        if (state != FIRST && in_rd == 5'd0) begin
            next_word = NOP;
        end
    end

    imm_encoder u_imm_encoder (
        .fmt    (enc_fmt),
        .imm    (enc_imm),
        .rs1    (enc_rs1),
        .funct3 (F3_ADDI),
        .rd     (enc_rd),
        .opcode (enc_op),
        .instr  (enc_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            instr_q <= '0;
            count_q <= '0;
            rd_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (handoff) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (accept || (handoff && state == FIRST)) begin
                state   <= next_state;
                instr_q <= next_word;
            end else if (handoff) begin
                state <= IDLE;
            end
            if (accept) begin
                rd_q <= in_rd;
                lo_q <= in_value[11:0];
            end
        end
    end

endmodule

// File: tb/tb_li_expander.sv
// Self-checking bench for li_expander: directed cases, backpressure, mid-expansion reset
// and randomized requests against an arithmetic reference model.
module tb_li_expander;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic [15:0] emit_count;

    int          checks;
    int          failures;
    logic [15:0] exp_emit;

    logic [31:0] got_instr[$];
    logic        got_last[$];
    int          first_delay;
    int          unstable;
    bit          timed_out;

    li_expander #(.CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_value   (in_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_last   (out_last),
        .emit_count (emit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm12);
        return (imm12 & 32'hFFF) * 32'h0010_0000 + 32'(rs1) * 32'h8000 + 32'(rd) * 32'h80 + 32'h13;
    endfunction

    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [31:0] imm20);
        return (imm20 & 32'hFFFFF) * 32'h1000 + 32'(rd) * 32'h80 + 32'h37;
    endfunction

    // Reference: pick the shortest sequence from value ranges, split the rest into hi*4096 + signed lo.
    function automatic void model(input logic [4:0] rd, input logic [31:0] v,
                                  output int n, output logic [31:0] w0, output logic [31:0] w1);
        int          sv;
        int          lo_signed;
        logic [31:0] hi;
        sv = int'(v);
        n  = 1;
        w1 = 32'h0;
        if (rd == 5'd0) begin
            w0 = 32'h0000_0013;
        end else if (sv >= -2048 && sv <= 2047) begin
            w0 = enc_addi(rd, 5'd0, v);
        end else if (v % 32'd4096 == 32'd0) begin
            w0 = enc_lui(rd, v / 32'd4096);
        end else begin
            lo_signed = int'(v % 32'd4096);
            if (lo_signed >= 2048) lo_signed = lo_signed - 4096;
            hi = (v - 32'(lo_signed)) / 32'd4096;
            n  = 2;
            w0 = enc_lui(rd, hi);
            w1 = enc_addi(rd, rd, 32'(lo_signed));
        end
    endfunction

    // Presents one request, waits for accept, then gathers words until out_last hands off.
    task automatic drive_and_collect(input logic [4:0] rd, input logic [31:0] value, input bit stall);
        bit   accepted;
        bit   done;
        bit   prev_stalled;
        logic [31:0] prev_instr;
        logic prev_last;
        accepted     = 1'b0;
        done         = 1'b0;
        prev_stalled = 1'b0;
        prev_instr   = '0;
        prev_last    = 1'b0;
        got_instr.delete();
        got_last.delete();
        first_delay = -1;
        unstable    = 0;
        timed_out   = 1'b0;
        in_rd     = rd;
        in_value  = value;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            #1;
            accepted = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_rd    = 5'($urandom);
        in_value = $urandom;
        if (!accepted) begin
            timed_out = 1'b1;
        end else begin
            for (int i = 0; i < 60 && !done; i++) begin
                out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                if (out_valid) begin
                    if (first_delay < 0) first_delay = i;
                    if (prev_stalled && (out_instr !== prev_instr || out_last !== prev_last)) unstable++;
                    if (out_ready) begin
                        got_instr.push_back(out_instr);
                        got_last.push_back(out_last);
                        done = out_last;
                    end
                    prev_stalled = !out_ready;
                    prev_instr   = out_instr;
                    prev_last    = out_last;
                end
                @(posedge clk); #1;
            end
            if (!done) timed_out = 1'b1;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_rd     = '0;
        in_value  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_out_instr: got %h expected 00000000", out_instr); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
        checks++; if (emit_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_emit_count: got %0d expected 0", emit_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        exp_emit = 16'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [4:0]  d_rd[6];
        logic [31:0] d_val[6];
        int          d_n[6];
        logic [31:0] d_w0[6];
        logic [31:0] d_w1[6];
        d_rd[0] = 5'd5;  d_val[0] = 32'h0000_0123; d_n[0] = 1; d_w0[0] = 32'h1230_0293; d_w1[0] = 32'h0;
        d_rd[1] = 5'd10; d_val[1] = 32'h1234_5000; d_n[1] = 1; d_w0[1] = 32'h1234_5537; d_w1[1] = 32'h0;
        d_rd[2] = 5'd1;  d_val[2] = 32'h0000_0800; d_n[2] = 2; d_w0[2] = 32'h0000_10B7; d_w1[2] = 32'h8000_8093;
        d_rd[3] = 5'd3;  d_val[3] = 32'h7FFF_F800; d_n[3] = 2; d_w0[3] = 32'h8000_01B7; d_w1[3] = 32'h8001_8193;
        d_rd[4] = 5'd0;  d_val[4] = 32'hDEAD_BEEF; d_n[4] = 1; d_w0[4] = 32'h0000_0013; d_w1[4] = 32'h0;
        d_rd[5] = 5'd7;  d_val[5] = 32'hFFFF_F800; d_n[5] = 1; d_w0[5] = 32'h8000_0393; d_w1[5] = 32'h0;
        for (int k = 0; k < 6; k++) begin
            drive_and_collect(d_rd[k], d_val[k], 1'b0);
            exp_emit = exp_emit + 16'(d_n[k]);
            checks++; if (timed_out) begin failures++; $display("[TB] FAIL dir%0d_timeout: got timeout expected completion", k); end
            checks++; if (got_instr.size() != d_n[k]) begin failures++; $display("[TB] FAIL dir%0d_count: got %0d words expected %0d", k, got_instr.size(), d_n[k]); end
            checks++; if (first_delay != 0) begin failures++; $display("[TB] FAIL dir%0d_latency: got %0d expected 0", k, first_delay); end
            if (got_instr.size() == d_n[k]) begin
                checks++; if (got_instr[0] !== d_w0[k]) begin failures++; $display("[TB] FAIL dir%0d_word0: got %h expected %h", k, got_instr[0], d_w0[k]); end
                checks++; if (got_last[0] !== (d_n[k] == 1)) begin failures++; $display("[TB] FAIL dir%0d_last0: got %b expected %b", k, got_last[0], d_n[k] == 1); end
                if (d_n[k] == 2) begin
                    checks++; if (got_instr[1] !== d_w1[k]) begin failures++; $display("[TB] FAIL dir%0d_word1: got %h expected %h", k, got_instr[1], d_w1[k]); end
                    checks++; if (got_last[1] !== 1'b1) begin failures++; $display("[TB] FAIL dir%0d_last1: got %b expected 1", k, got_last[1]); end
                end
            end
            checks++; if (emit_count !== exp_emit) begin failures++; $display("[TB] FAIL dir%0d_emit_count: got %0d expected %0d", k, emit_count, exp_emit); end
        end
    endtask

    task automatic test_back_to_back();
        in_rd     = 5'd1;
        in_value  = 32'h0000_0800;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_idle_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_rd    = 5'd5;
        in_value = 32'h0000_0123;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (out_instr !== 32'h0000_10B7) begin failures++; $display("[TB] FAIL bp_hold_instr%0d: got %h expected 000010b7", k, out_instr); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_hold_ready%0d: got %b expected 0", k, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_last !== 1'b0) begin failures++; $display("[TB] FAIL bp_hold_flags%0d: got valid=%b last=%b expected valid=1 last=0", k, out_valid, out_last); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_emit = exp_emit + 16'd1;
        #1;
        checks++; if (out_instr !== 32'h8000_8093 || out_last !== 1'b1) begin failures++; $display("[TB] FAIL bp_second: got %h last=%b expected 80008093 last=1", out_instr, out_last); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_same_cycle_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        exp_emit = exp_emit + 16'd1;
        in_valid = 1'b0;
        in_value = 32'hFFFF_FFFF;
        #1;
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h1230_0293 || out_last !== 1'b1) begin failures++; $display("[TB] FAIL bp_no_bubble: got valid=%b %h last=%b expected valid=1 12300293 last=1", out_valid, out_instr, out_last); end
        @(posedge clk); #1;
        exp_emit = exp_emit + 16'd1;
        #1;
        checks++; if (out_valid !== 1'b0 || emit_count !== exp_emit) begin failures++; $display("[TB] FAIL bp_end: got valid=%b count=%0d expected valid=0 count=%0d", out_valid, emit_count, exp_emit); end
    endtask

    task automatic test_reset_in_second();
        int seen;
        seen      = 0;
        in_rd     = 5'd2;
        in_value  = 32'h1234_5678;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        #1;
        checks++; if (out_instr !== 32'h6781_0113 || out_last !== 1'b1) begin failures++; $display("[TB] FAIL rst2_in_second: got %h last=%b expected 67810113 last=1", out_instr, out_last); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst2_out_valid: got %b expected 0", out_valid); end
        checks++; if (emit_count !== 16'd0) begin failures++; $display("[TB] FAIL rst2_emit_count: got %0d expected 0", emit_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst2_in_ready: got %b expected 1", in_ready); end
        exp_emit  = 16'd0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("[TB] FAIL rst2_no_addi: got %0d valid cycles expected 0", seen); end
        checks++; if (emit_count !== 16'd0) begin failures++; $display("[TB] FAIL rst2_count_after: got %0d expected 0", emit_count); end
    endtask

    task automatic test_random();
        logic [4:0]  rd;
        logic [31:0] v;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        for (int k = 0; k < 40; k++) begin
            rd = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0:       v = {{20{1'($urandom)}}, 12'($urandom)};
                1:       v = $urandom & 32'hFFFF_F000;
                2:       v = {20'($urandom), 12'h800};
                default: v = $urandom;
            endcase
            model(rd, v, n, w0, w1);
            drive_and_collect(rd, v, 1'b1);
            exp_emit = exp_emit + 16'(n);
            checks++; if (timed_out || got_instr.size() != n) begin failures++; $display("[TB] FAIL rnd%0d_count: got %0d words timeout=%b expected %0d (rd=%0d v=%h)", k, got_instr.size(), timed_out, n, rd, v); end
            if (!timed_out && got_instr.size() == n) begin
                checks++; if (got_instr[0] !== w0 || got_last[0] !== (n == 1)) begin failures++; $display("[TB] FAIL rnd%0d_word0: got %h last=%b expected %h last=%b", k, got_instr[0], got_last[0], w0, n == 1); end
                if (n == 2) begin
                    checks++; if (got_instr[1] !== w1 || got_last[1] !== 1'b1) begin failures++; $display("[TB] FAIL rnd%0d_word1: got %h last=%b expected %h last=1", k, got_instr[1], got_last[1], w1); end
                end
            end
            checks++; if (unstable != 0 || first_delay != 0) begin failures++; $display("[TB] FAIL rnd%0d_stable: got unstable=%0d delay=%0d expected 0 and 0", k, unstable, first_delay); end
            checks++; if (emit_count !== exp_emit) begin failures++; $display("[TB] FAIL rnd%0d_emit_count: got %0d expected %0d", k, emit_count, exp_emit); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_emit = 16'd0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_in_second();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
